// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU register front-end for one uart core.
// Buffers TX/RX bytes, sequences the core handshakes, holds the baud divisor and drives the RX irq.
//   state      | meaning
//   TX_IDLE    | waiting for a queued byte and tx_done low
//   TX_START   | start_tx high, waiting for tx_done
//   TX_RELEASE | start_tx low, waiting for tx_done to drop
//   RX_WAIT    | waiting for rx_available with room in the RX FIFO
//   RX_CLEAR   | rx_clear high until the core drops rx_available
module uart_ctrl #(
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [11:0] BAUD_DEFAULT = 12'd103
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bus_addr,
   input  logic        bus_wr,
   input  logic        bus_rd,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        irq,
   output logic        start_tx,
   output logic [7:0]  tx_value,
   input  logic        tx_done,
   input  logic        rx_available,
   input  logic [7:0]  rx_value,
   output logic        rx_clear,
   output logic [11:0] uart_baud_counter
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_RELEASE} tx_state_t;
   typedef enum logic {RX_WAIT, RX_CLEAR} rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt;
   logic          tx_full, tx_empty, rx_full, rx_empty, tx_busy;
   logic          tx_push, tx_pop, tx_drop, rx_push, rx_pop;
   logic          irq_en, tx_ovf;
   logic [11:0]   baud;
   logic [7:0]    status, rd_mux;

   assign tx_cnt   = tx_wp - tx_rp;
   assign rx_cnt   = rx_wp - rx_rp;
   assign tx_full  = (tx_cnt == FULL_CNT);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign tx_empty = (tx_cnt == '0);
   assign rx_empty = (rx_cnt == '0);
   assign tx_busy  = (tx_state != TX_IDLE);

   // Full-FIFO pushes are rejected on the current count, even if a pop frees a slot this cycle.
   assign tx_push = bus_wr && (bus_addr == 2'd0) && !tx_full;
   assign tx_drop = bus_wr && (bus_addr == 2'd0) && tx_full;
   assign rx_pop  = bus_rd && (bus_addr == 2'd0) && !rx_empty;

   assign status            = {1'b0, irq_en, tx_ovf, tx_busy, tx_full, tx_empty, rx_full, !rx_empty};
   assign irq               = irq_en && !rx_empty;
   assign uart_baud_counter = baud;

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE:
            if (!tx_empty && !tx_done) begin
               tx_pop  = 1'b1;
               tx_next = TX_START;
            end
         TX_START:   if (tx_done)  tx_next = TX_RELEASE;
         TX_RELEASE: if (!tx_done) tx_next = TX_IDLE;
         default:    tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      case (rx_state)
         RX_WAIT:
            if (rx_available && !rx_full) begin
               rx_push = 1'b1;
               rx_next = RX_CLEAR;
            end
         RX_CLEAR: if (!rx_available) rx_next = RX_WAIT;
         default:  rx_next = RX_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         rx_state <= RX_WAIT;
         start_tx <= 1'b0;
         rx_clear <= 1'b0;
      end else begin
         tx_state <= tx_next;
         rx_state <= rx_next;
         start_tx <= (tx_next == TX_START);
         rx_clear <= (rx_next == RX_CLEAR);
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      case (bus_addr)
         2'd0:    rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
         2'd1:    rd_mux = status;
         2'd2:    rd_mux = baud[7:0];
         default: rd_mux = {4'h0, baud[11:8]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus_wdata;
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         tx_value  <= 8'h00;
         bus_rdata <= 8'h00;
         irq_en    <= 1'b0;
         tx_ovf    <= 1'b0;
         baud      <= BAUD_DEFAULT;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop) begin
            tx_rp    <= tx_rp + PW'(1);
            tx_value <= tx_mem[tx_rp[AW-1:0]];
         end
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
         if (bus_rd)  bus_rdata <= rd_mux;
         if (tx_drop) tx_ovf <= 1'b1;
         if (bus_wr && (bus_addr == 2'd1)) begin
            irq_en <= bus_wdata[6];
            if (bus_wdata[5]) tx_ovf <= 1'b0;
         end
         // The divisor is frozen while a byte is being handed to the core.
         if (bus_wr && !tx_busy) begin
            if (bus_addr == 2'd2) baud[7:0]  <= bus_wdata;
            if (bus_addr == 2'd3) baud[11:8] <= bus_wdata[3:0];
         end
      end
   end
endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed scenarios plus a random phase, with a stub uart core.
// Read data and TX bytes are checked by monitors against queues filled at stimulus time.
module tb_uart_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  bus_addr = 2'd0;
   logic        bus_wr = 1'b0;
   logic        bus_rd = 1'b0;
   logic [7:0]  bus_wdata = 8'h00;
   logic [7:0]  bus_rdata;
   logic        irq;
   logic        start_tx;
   logic [7:0]  tx_value;
   logic        tx_done = 1'b0;
   logic        rx_available = 1'b0;
   logic [7:0]  rx_value = 8'h00;
   logic        rx_clear;
   logic [11:0] uart_baud_counter;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] rx_m[$];
   bit         core_stall = 1'b1;
   int         core_delay = 20;

   uart_ctrl dut (
      .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq), .start_tx(start_tx),
      .tx_value(tx_value), .tx_done(tx_done), .rx_available(rx_available),
      .rx_value(rx_value), .rx_clear(rx_clear), .uart_baud_counter(uart_baud_counter)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
      cyc();
      bus_wr = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp);
      bus_addr = a; bus_rd = 1'b1;
      rd_q.push_back(exp);
      cyc();
      bus_rd = 1'b0;
   endtask

   task automatic rd_data();
      logic [7:0] e;
      e = 8'h00;
      if (rx_m.size() != 0) e = rx_m.pop_front();
      rd(2'd0, e);
   endtask

   task automatic tx_write(input logic [7:0] d);
      tx_q.push_back(d);
      wr(2'd0, d);
   endtask

   task automatic rx_send(input logic [7:0] d, input int hold);
      int n;
      n = 0;
      rx_value = d; rx_available = 1'b1;
      rx_m.push_back(d);
      while (!rx_clear && n < 40) begin cyc(); n++; end
      if (!rx_clear) fail_now("rx_accept");
      for (int i = 0; i < hold; i++) begin
         cyc();
         chk("rx_clear_hold", 12'(rx_clear), 12'h1);
      end
      rx_available = 1'b0;
      cyc();
      chk("rx_clear_drop", 12'(rx_clear), 12'h0);
   endtask

   task automatic wait_tx_idle();
      int n;
      n = 0;
      while ((tx_q.size() != 0 || start_tx || tx_done) && n < 3000) begin cyc(); n++; end
      if (n >= 3000) fail_now("tx_drain");
      cyc(3);
   endtask

   // Read-data monitor: bus_rdata is due the cycle after the strobe.
   logic rd_d = 1'b0;
   always @(posedge clk) rd_d <= bus_rd;
   always @(negedge clk) begin
      if (rd_d) begin
         if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got 0x%0h expected no read", bus_rdata);
         end else begin
            chk("bus_rdata", 12'(bus_rdata), 12'(rd_q.pop_front()));
         end
      end
   end

   // TX monitor: each start_tx rise must present the next accepted byte, held steady.
   logic       start_prev = 1'b0;
   logic [7:0] cur_tx = 8'h00;
   always @(negedge clk) begin
      start_prev <= start_tx;
      if (start_tx && !start_prev) begin
         cur_tx <= tx_value;
         if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_value);
         end else begin
            chk("tx_value", 12'(tx_value), 12'(tx_q.pop_front()));
         end
      end else if (start_tx) begin
         chk("tx_stable", 12'(tx_value), 12'(cur_tx));
      end
   end

   // Stub core: answers start_tx with a tx_done pulse after core_delay cycles.
   initial begin
      forever begin
         cyc();
         if (start_tx && !core_stall) begin
            cyc(core_delay);
            tx_done = 1'b1;
            cyc();
            chk("start_drop", 12'(start_tx), 12'h0);
            tx_done = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int n;

      // Reset values
      cyc(2);
      chk("rst_start_tx", 12'(start_tx), 12'h0);
      chk("rst_rx_clear", 12'(rx_clear), 12'h0);
      chk("rst_tx_value", 12'(tx_value), 12'h0);
      chk("rst_rdata", 12'(bus_rdata), 12'h0);
      chk("rst_irq", 12'(irq), 12'h0);
      chk("rst_baud", uart_baud_counter, 12'd103);
      rst = 1'b0;
      cyc();
      rd(2'd1, 8'h04);

      // TX of two bytes through the stub core
      core_stall = 1'b0; core_delay = 20;
      tx_write(8'h55);
      tx_write(8'hA3);
      wait_tx_idle();
      rd(2'd1, 8'h04);

      // TX overflow: one byte in flight plus a full FIFO, sixth write dropped
      core_stall = 1'b1;
      for (int i = 0; i < 5; i++) tx_write(8'h10 + 8'(i));
      rd(2'd1, 8'h18);
      wr(2'd0, 8'hEE);
      rd(2'd1, 8'h38);
      wr(2'd2, 8'hFF);
      chk("baud_busy_lo", uart_baud_counter, 12'd103);
      rd(2'd2, 8'h67);
      wr(2'd1, 8'h20);
      rd(2'd1, 8'h18);
      core_stall = 1'b0; core_delay = 3;
      wait_tx_idle();
      rd(2'd1, 8'h04);

      // RX with interrupt
      wr(2'd1, 8'h40);
      rx_send(8'h3C, 2);
      rx_send(8'h7E, 0);
      chk("irq_two", 12'(irq), 12'h1);
      rd_data();
      chk("irq_one", 12'(irq), 12'h1);
      rd_data();
      chk("irq_empty", 12'(irq), 12'h0);
      rd(2'd1, 8'h44);
      rd_data();

      // RX full backpressure
      for (int i = 0; i < 4; i++) rx_send(8'hC0 + 8'(i), 0);
      rd(2'd1, 8'h47);
      rx_value = 8'hC4; rx_available = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rx_full_hold", 12'(rx_clear), 12'h0);
      end
      rd_data();
      chk("rx_full_after_pop", 12'(rx_clear), 12'h0);
      cyc();
      chk("rx_late_push", 12'(rx_clear), 12'h1);
      rx_m.push_back(8'hC4);
      rx_available = 1'b0;
      cyc();
      chk("rx_late_drop", 12'(rx_clear), 12'h0);
      rd(2'd1, 8'h47);
      rd_data();
      // Arrival and CPU pop in the same cycle
      rx_value = 8'h99; rx_available = 1'b1;
      bus_addr = 2'd0; bus_rd = 1'b1;
      rd_q.push_back(rx_m.pop_front());
      rx_m.push_back(8'h99);
      cyc();
      bus_rd = 1'b0;
      chk("rx_simul_push", 12'(rx_clear), 12'h1);
      rx_available = 1'b0;
      cyc();
      rd(2'd1, 8'h45);
      while (rx_m.size() != 0) rd_data();
      rd_data();
      chk("irq_drained", 12'(irq), 12'h0);

      // Baud register
      wr(2'd3, 8'h01);
      chk("baud_hi", uart_baud_counter, 12'h167);
      wr(2'd2, 8'h20);
      chk("baud_lo", uart_baud_counter, 12'h120);
      rd(2'd2, 8'h20);
      rd(2'd3, 8'h01);
      core_stall = 1'b1;
      tx_write(8'h5A);
      n = 0;
      while (!start_tx && n < 20) begin cyc(); n++; end
      if (!start_tx) fail_now("tx_start_wait");
      wr(2'd3, 8'h0F);
      chk("baud_busy_hi", uart_baud_counter, 12'h120);
      cyc();
      rst = 1'b1;
      #1;
      chk("rst_mid_start_tx", 12'(start_tx), 12'h0);
      chk("rst_mid_tx_value", 12'(tx_value), 12'h0);
      chk("rst_mid_baud", uart_baud_counter, 12'd103);
      cyc(2);
      rst = 1'b0;
      cyc();
      rd(2'd1, 8'h04);

      // Random traffic
      core_stall = 1'b0;
      for (int it = 0; it < 80; it++) begin
         core_delay = $urandom_range(1, 6);
         case ($urandom_range(0, 2))
            0: if (tx_q.size() < 4) begin
                  b = 8'($urandom);
                  tx_write(b);
               end
            1: if (rx_m.size() < 4) begin
                  b = 8'($urandom);
                  rx_send(b, $urandom_range(0, 2));
               end
            default: rd_data();
         endcase
         cyc($urandom_range(0, 2));
      end
      wait_tx_idle();
      while (rx_m.size() != 0) rd_data();
      rd(2'd1, 8'h04);
      cyc(3);
      if (rd_q.size() != 0) fail_now("rd_pending");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
